// File: rtl/weight_bank_pkg.sv
// Shared types and helpers for the weight_bank store.
package weight_bank_pkg;

  localparam int DEF_DATA_WIDTH = 16;

  // Signed Q8.8 weight/bias word at the default width.
  typedef logic signed [DEF_DATA_WIDTH-1:0] weight_t;

  // Read-side FSM: idle, or streaming one neuron's words.
  typedef enum logic {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  // Index width for a range of n values; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/weight_bank_mem.sv
// Register-array weight store: one write port, one registered read port.
module weight_bank_mem
  import weight_bank_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = 10,
  parameter int AW         = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port and registered read; reset clears every stored word.
  // NOTE: the array is reset word by word because a reset bank must read back
  // as zeros; that keeps it in flops instead of a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      // NOTE: non-blocking assignments so the read sees the pre-write array
      // and simulation matches the registers that get built.
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/weight_bank.sv
// Loadable weight/bias bank streaming one neuron's words to the MAC datapath.
// Build option: define WEIGHT_BANK_SHADOW_EN for an active/shadow bank pair
// so a new weight set can load while the current one is being streamed.
module weight_bank
  import weight_bank_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int N_IN       = 9,
  parameter  int N_NEURONS  = 1,
  localparam int NW         = idx_width(N_NEURONS),
  localparam int IW         = idx_width(N_IN + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_last,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [NW-1:0]         rd_neuron,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [IW-1:0]         out_idx,
  output logic                  out_last,
  output logic                  loaded,
  output logic                  err
);

  localparam int STRIDE = N_IN + 1;
  localparam int TOTAL  = N_NEURONS * STRIDE;
  localparam int AW     = idx_width(TOTAL);

  state_t          state_q, state_d;
  logic [AW-1:0]   ld_cnt, rd_addr, rd_addr_d, base_addr;
  logic [IW-1:0]   idx_q, idx_d;
  logic            rd_fire, out_fire, ld_fire;
  logic            ld_at_end, ld_good, ld_bad, is_last;

  assign is_last   = (idx_q == IW'(N_IN));
  assign out_valid = (state_q == S_STREAM);
  assign out_idx   = idx_q;
  assign out_last  = out_valid && is_last;
  assign rd_ready  = (state_q == S_IDLE) && loaded;
  assign rd_fire   = rd_valid && rd_ready;
  assign out_fire  = out_valid && out_ready;
  assign ld_fire   = ld_valid && ld_ready;
  assign ld_at_end = (ld_cnt == AW'(TOTAL - 1));
  assign ld_good   = ld_fire && ld_last && ld_at_end;
  assign ld_bad    = ld_fire && (ld_last != ld_at_end);
  // A single-neuron bank has only one base; the index input is ignored.
  assign base_addr = (N_NEURONS > 1) ? AW'(rd_neuron) * AW'(STRIDE) : '0;

  // Next read state.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (rd_fire) state_d = S_STREAM;
      S_STREAM: if (out_fire && is_last) state_d = S_IDLE;
    endcase
  end

  // Next read address and word index; held while the consumer stalls so the
  // registered read port keeps presenting the same word.
  always_comb begin
    rd_addr_d = rd_addr;
    idx_d     = idx_q;
    if (rd_fire) begin
      rd_addr_d = base_addr;
      idx_d     = '0;
    end else if (out_fire && !is_last) begin
      rd_addr_d = rd_addr + AW'(1);
      idx_d     = idx_q + IW'(1);
    end
  end

  // Read FSM and stream counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rd_addr <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      rd_addr <= rd_addr_d;
      idx_q   <= idx_d;
    end
  end

  // Load word counter and sticky word-count error.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_cnt <= '0;
      err    <= 1'b0;
    end else if (ld_fire) begin
      ld_cnt <= (ld_good || ld_bad) ? '0 : ld_cnt + AW'(1);
      if (ld_bad)            err <= 1'b1;
      else if (ld_cnt == '0) err <= 1'b0;
    end
  end

`ifdef WEIGHT_BANK_SHADOW_EN
  logic                  active, swap_pending, swap;
  logic [DATA_WIDTH-1:0] rdata0, rdata1;

  assign ld_ready = 1'b1;
  assign swap     = swap_pending && (state_q == S_IDLE);
  assign out_data = active ? rdata1 : rdata0;

  // Bank swap: a completed shadow load becomes active at the next idle cycle.
  // A good load finishing in a swap cycle wrote the bank being activated, so
  // no further swap is owed.
  always_ff @(posedge clk) begin
    if (rst) begin
      active       <= 1'b0;
      swap_pending <= 1'b0;
      loaded       <= 1'b0;
    end else if (swap) begin
      active       <= ~active;
      swap_pending <= 1'b0;
      loaded       <= 1'b1;
    end else if (ld_good) begin
      swap_pending <= 1'b1;
    end
  end

  weight_bank_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(TOTAL), .AW(AW)) u_bank0 (
    .clk(clk), .rst(rst), .we(ld_fire && active), .waddr(ld_cnt),
    .wdata(ld_data), .raddr(rd_addr_d), .rdata(rdata0)
  );
  weight_bank_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(TOTAL), .AW(AW)) u_bank1 (
    .clk(clk), .rst(rst), .we(ld_fire && !active), .waddr(ld_cnt),
    .wdata(ld_data), .raddr(rd_addr_d), .rdata(rdata1)
  );
`else
  assign ld_ready = (state_q == S_IDLE);

  // Readable flag: dropped by the first word of any load so a partial bank is
  // never streamed, raised only by a correctly terminated load.
  always_ff @(posedge clk) begin
    if (rst) begin
      loaded <= 1'b0;
    end else if (ld_fire) begin
      if (ld_good)                      loaded <= 1'b1;
      else if (ld_bad || ld_cnt == '0) loaded <= 1'b0;
    end
  end

  weight_bank_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(TOTAL), .AW(AW)) u_bank0 (
    .clk(clk), .rst(rst), .we(ld_fire), .waddr(ld_cnt),
    .wdata(ld_data), .raddr(rd_addr_d), .rdata(out_data)
  );
`endif

endmodule

// File: tb/tb_weight_bank.sv
// Self-checking bench for weight_bank (single-bank build, N_IN=9, N_NEURONS=2).
module tb_weight_bank;

  localparam int DW    = 16;
  localparam int NI    = 9;
  localparam int NN    = 2;
  localparam int WPN   = NI + 1;
  localparam int TOTAL = NN * WPN;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ld_valid = 1'b0, ld_last = 1'b0, rd_valid = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] ld_data = '0;
  logic          rd_neuron = 1'b0;
  logic          ld_ready, rd_ready, out_valid, out_last, loaded, err;
  logic [DW-1:0] out_data;
  logic [3:0]    out_idx;

  // Reference state: bank contents and the two status flags.
  logic [DW-1:0] model_mem [TOTAL];
  logic          model_loaded, model_err;
  int            n_cmp = 0;
  int            n_bad = 0;

  weight_bank #(.DATA_WIDTH(DW), .N_IN(NI), .N_NEURONS(NN)) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_neuron(rd_neuron),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .loaded(loaded), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before summary (observed hang, expected finish)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_cmp++;
    n_bad++;
    $error("FAIL %s: observed timeout expected handshake", tag);
  endtask

  task automatic model_reset();
    for (int i = 0; i < TOTAL; i++) model_mem[i] = '0;
    model_loaded = 1'b0;
    model_err    = 1'b0;
  endtask

  task automatic check_idle_status(input string tag);
    chk({tag, "_loaded"}, 32'(loaded), 32'(model_loaded));
    chk({tag, "_err"}, 32'(err), 32'(model_err));
    chk({tag, "_rd_ready"}, 32'(rd_ready), 32'(model_loaded));
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
  endtask

  // Load n words (mode 0: base+i, 1: random, 2: zeros); ld_last on the final
  // word when with_last. The sequence is good only if it is exactly TOTAL long
  // and terminated by ld_last.
  task automatic load(input int n, input bit with_last, input int mode, input int base);
    logic [DW-1:0] w;
    int guard;
    for (int i = 0; i < n; i++) begin
      w = (mode == 0) ? DW'(base + i) : (mode == 1) ? DW'($urandom) : '0;
      ld_valid = 1'b1;
      ld_data  = w;
      ld_last  = with_last && (i == n - 1);
      guard = 0;
      do begin @(negedge clk); guard++; end while (!ld_ready && guard < 50);
      if (!ld_ready) begin timeout("ld_ready"); ld_valid = 1'b0; return; end
      @(posedge clk); #1;
      model_mem[i] = w;
      if (i == 0 && n > 1) begin
        ld_valid = 1'b0;
        @(negedge clk);
        chk("first_word_err", 32'(err), 0);
        chk("first_word_loaded", 32'(loaded), 0);
        @(posedge clk); #1;
      end
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    model_loaded = with_last && (n == TOTAL);
    model_err    = !model_loaded;
    @(negedge clk);
    check_idle_status("after_load");
    @(posedge clk); #1;
  endtask

  // Read neuron n; optional random consumer stalls, optional load attempt
  // during the stream, and optional early stop after abort_at accepted words.
  task automatic stream(input int n, input bit stalls, input bit ld_probe, input int abort_at);
    int k, guard;
    logic [DW-1:0] held;
    bit was_stalled;
    rd_neuron = 1'(n);
    rd_valid  = 1'b1;
    guard = 0;
    do begin @(negedge clk); guard++; end while (!rd_ready && guard < 50);
    if (!rd_ready) begin timeout("rd_ready"); rd_valid = 1'b0; return; end
    @(posedge clk); #1;
    rd_valid = 1'b0;
    if (ld_probe) begin ld_valid = 1'b1; ld_data = 16'hdead; ld_last = 1'b0; end
    k = 0;
    guard = 0;
    was_stalled = 1'b0;
    held = '0;
    while (k < WPN && k != abort_at && guard < 200) begin
      out_ready = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
      guard++;
      chk("out_valid", 32'(out_valid), 1);
      if (was_stalled) chk("stall_hold", 32'(out_data), 32'(held));
      if (ld_probe) chk("ld_ready_in_stream", 32'(ld_ready), 0);
      if (out_ready) begin
        chk("out_data", 32'(out_data), 32'(model_mem[n * WPN + k]));
        chk("out_idx", 32'(out_idx), k);
        chk("out_last", 32'(out_last), 32'(k == NI));
        if (ld_probe && k == NI) ld_valid = 1'b0;
        k++;
        was_stalled = 1'b0;
      end else begin
        held = out_data;
        was_stalled = 1'b1;
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    ld_valid  = 1'b0;
    if (guard >= 200) timeout("stream_words");
    if (abort_at < 0) begin
      @(negedge clk);
      chk("stream_end_valid", 32'(out_valid), 0);
      chk("stream_end_last", 32'(out_last), 0);
      if (ld_probe) chk("ld_ready_after_stream", 32'(ld_ready), 1);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_loaded", 32'(loaded), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_ld_ready", 32'(ld_ready), 1);
    chk("rst_rd_ready", 32'(rd_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed incrementing load, then both neurons with and without stalls.
    load(TOTAL, 1'b1, 0, 'h0100);
    stream(1, 1'b0, 1'b0, -1);
    stream(0, 1'b1, 1'b0, -1);

    // Random weights; a blocked load attempt during the stream must not land.
    load(TOTAL, 1'b1, 1, 0);
    stream(1, 1'b1, 1'b1, -1);
    stream(0, 1'b1, 1'b0, -1);

    // Early ld_last, then a read request that must be held off.
    load(15, 1'b1, 0, 'h0200);
    rd_neuron = 1'b0;
    rd_valid  = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("held_off_rd_ready", 32'(rd_ready), 0);
      chk("held_off_out_valid", 32'(out_valid), 0);
      @(posedge clk); #1;
    end
    rd_valid = 1'b0;

    // Full-length sequence missing ld_last, then a good recovery load.
    load(TOTAL, 1'b0, 1, 0);
    load(TOTAL, 1'b1, 0, 'h0100);
    stream(1, 1'b1, 1'b0, -1);

    // Reset in the middle of a stream.
    stream(1, 1'b0, 1'b0, 4);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    model_reset();
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_loaded", 32'(loaded), 0);
    chk("midrst_err", 32'(err), 0);
    chk("midrst_ld_ready", 32'(ld_ready), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    load(TOTAL, 1'b1, 2, 0);
    stream(0, 1'b1, 1'b0, -1);
    stream(1, 1'b0, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
